// File: rtl/mem_ctrl_pkg.sv
// Shared MEM-stage definitions: FSM encoding, load/store opcodes and the default timeout.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Major opcodes shared with decode and immediate generation
   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;

   localparam int MAX_WAIT_DEF = 64;
   localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// MEM-stage <-> data memory bundle; master is the stall controller, slave is pipeline plus memory.
interface mem_stall_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              memread_i;
   logic              memwrite_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              stall_o;
   logic [DATA_W-1:0] rdata_o;
   logic              err_o;
   logic [31:0]       stall_cycles_o;

   modport master (
      input  memread_i, memwrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, rdata_o,
             err_o, stall_cycles_o
   );

   modport slave (
      output memread_i, memwrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, rdata_o,
             err_o, stall_cycles_o
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Loadable wait counter; tc flags the cycle whose increment reaches MAX_WAIT.
module mem_wait_timer #(
   parameter int CNT_W    = 8,
   parameter int MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = en && (cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage lw/sw sequencer over a req/ack memory port, driving the pipeline-wide stall.
// Optional stall-cycle performance counter built only when MEM_STALL_PERF_EN is defined.
module mem_stall_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_stall_ctrl_if.master bus
);

   state_t            state, state_nxt;
   logic              go;
   logic              stall;
   logic              tmo;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   assign go = bus.memread_i | bus.memwrite_i;

   mem_wait_timer #(
      .CNT_W    (CNT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .clr      (state == DONE),
      .load     ((state == IDLE) && go),
      .load_val ('0),
      .en       (state == REQ),
      .tc       (tmo)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (go) state_nxt = REQ;
         REQ:     if (bus.mem_ack_i || tmo) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Store wins when both strobes are high: we simply latches memwrite_i.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state == IDLE) && go) begin
            we_q    <= bus.memwrite_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
         end
         if (state == REQ) begin
            if (bus.mem_ack_i) begin
               if (!we_q) rdata_q <= bus.mem_rdata_i;
            end else if (tmo) begin
               err_q   <= 1'b1;
               rdata_q <= '0;
            end
         end
      end
   end

   // Request is decoded from state so it falls with the asynchronous reset.
   assign stall           = ((state == IDLE) && go) || (state == REQ);
   assign bus.stall_o     = stall;
   assign bus.mem_req_o   = (state == REQ);
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.rdata_o     = rdata_q;
   assign bus.err_o       = err_q;

`ifdef MEM_STALL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         perf_q <= '0;
      end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign bus.stall_cycles_o = perf_q;
`else
   assign bus.stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: expected accesses are queued at issue and checked at DONE.
module tb_mem_stall_ctrl;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        done_stall;
      int          stall;
      int          req;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   txn_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_stall_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_stall_ctrl #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .MAX_WAIT (4),
      .CNT_W    (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic err, input int stall, input int req);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      t.err = err; t.done_stall = 1'b0; t.stall = stall; t.req = req;
      exp_q.push_back(t);
   endtask

   // Presents one access, plays the memory (ack on REQ cycle ack_at, 0 = never), returns what was seen.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at, input logic [31:0] rdat,
                            output txn_t obs, output int first_req_cyc, output int done_cyc);
      obs = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, rdata: 32'd0, err: 1'b0,
              done_stall: 1'b0, stall: 0, req: 0};
      first_req_cyc = -1;
      done_cyc = -1;
      @(negedge clk);
      bus.memread_i = rd; bus.memwrite_i = wr; bus.addr_i = addr; bus.wdata_i = wdata;
      #1;
      for (int n = 0; n < 300; n++) begin
         bus.mem_ack_i = 1'b0;
         bus.mem_rdata_i = 32'd0;
         if (bus.mem_req_o === 1'b1) begin
            obs.req++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            obs.we = bus.mem_we_o; obs.addr = bus.mem_addr_o; obs.wdata = bus.mem_wdata_o;
            if (obs.req == ack_at) begin
               bus.mem_ack_i = 1'b1;
               bus.mem_rdata_i = rdat;
            end
         end else if (obs.req > 0) begin
            // DONE: strobes are still held high here and must not re-trigger a stall
            obs.rdata = bus.rdata_o; obs.err = bus.err_o; obs.done_stall = bus.stall_o;
            done_cyc = cyc;
            bus.memread_i = 1'b0; bus.memwrite_i = 1'b0;
            break;
         end
         if (bus.stall_o === 1'b1) obs.stall++;
         @(negedge clk);
         #1;
      end
      if (done_cyc < 0) begin
         vectors++; miscompares++;
         $display("FAIL access_bound: no DONE within 300 cycles, want completion");
         bus.memread_i = 1'b0; bus.memwrite_i = 1'b0;
      end
   endtask

   task automatic check_txn(input string name, input txn_t o);
      txn_t e;
      if (exp_q.size() == 0) begin
         vectors++; miscompares++;
         $display("FAIL %s_sb: observed access with empty scoreboard", name);
         return;
      end
      e = exp_q.pop_front();
      vectors++; if (o.req !== e.req) begin miscompares++; $display("FAIL %s_req_cycles: got %0d want %0d", name, o.req, e.req); end
      vectors++; if (o.stall !== e.stall) begin miscompares++; $display("FAIL %s_stall_cycles: got %0d want %0d", name, o.stall, e.stall); end
      vectors++; if (o.we !== e.we) begin miscompares++; $display("FAIL %s_we: got %b want %b", name, o.we, e.we); end
      vectors++; if (o.addr !== e.addr) begin miscompares++; $display("FAIL %s_addr: got %h want %h", name, o.addr, e.addr); end
      if (e.we) begin
         vectors++; if (o.wdata !== e.wdata) begin miscompares++; $display("FAIL %s_wdata: got %h want %h", name, o.wdata, e.wdata); end
      end
      vectors++; if (o.rdata !== e.rdata) begin miscompares++; $display("FAIL %s_rdata: got %h want %h", name, o.rdata, e.rdata); end
      vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL %s_err: got %b want %b", name, o.err, e.err); end
      vectors++; if (o.done_stall !== 1'b0) begin miscompares++; $display("FAIL %s_done_stall: got %b want 0", name, o.done_stall); end
   endtask

   task automatic test_reset();
      bus.memread_i = 0; bus.memwrite_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
      bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus.mem_req_o); end
      vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
      vectors++; if (bus.mem_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", bus.mem_we_o); end
      vectors++; if (bus.mem_addr_o !== 32'd0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr_o); end
      vectors++; if (bus.rdata_o !== 32'd0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.rdata_o); end
      vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
      vectors++; if (bus.stall_cycles_o !== 32'd0) begin miscompares++; $display("FAIL rst_perf: got %0d want 0", bus.stall_cycles_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_lw();
      txn_t o; int f, d;
      push_exp(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, 3);
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, o, f, d);
      check_txn("lw", o);
   endtask

   task automatic test_sw();
      txn_t o; int f, d;
      // both strobes high: store wins, load data path untouched
      push_exp(1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF, 1'b0, 2, 1);
      do_access(1'b1, 1'b1, 32'h20, 32'h12345678, 1, 32'hFFFF0000, o, f, d);
      check_txn("sw", o);
   endtask

   task automatic test_perf();
      logic [31:0] want;
`ifdef MEM_STALL_PERF_EN
      want = 32'd6;
`else
      want = 32'd0;
`endif
      vectors++; if (bus.stall_cycles_o !== want) begin miscompares++; $display("FAIL perf_count: got %0d want %0d", bus.stall_cycles_o, want); end
   endtask

   task automatic test_back_to_back();
      txn_t o1, o2; int f1, d1, f2, d2;
      push_exp(1'b0, 32'h4, 32'h0, 32'hA0A0A0A0, 1'b0, 3, 2);
      push_exp(1'b0, 32'h8, 32'h0, 32'hB1B1B1B1, 1'b0, 2, 1);
      do_access(1'b1, 1'b0, 32'h4, 32'h0, 2, 32'hA0A0A0A0, o1, f1, d1);
      do_access(1'b1, 1'b0, 32'h8, 32'h0, 1, 32'hB1B1B1B1, o2, f2, d2);
      check_txn("b2b_first", o1);
      check_txn("b2b_second", o2);
      // DONE, one IDLE, then REQ of the second access
      vectors++; if (f2 - d1 !== 2) begin miscompares++; $display("FAIL b2b_gap: got %0d want 2", f2 - d1); end
   endtask

   task automatic test_timeout();
      txn_t o; int f, d;
      push_exp(1'b0, 32'h44, 32'h0, 32'h0, 1'b1, 5, 4);
      do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h0, o, f, d);
      check_txn("tmo", o);
      push_exp(1'b0, 32'h48, 32'h0, 32'h00000055, 1'b1, 3, 2);
      do_access(1'b1, 1'b0, 32'h48, 32'h0, 2, 32'h00000055, o, f, d);
      check_txn("tmo_sticky", o);
   endtask

   task automatic test_reset_mid();
      txn_t o; int f, d;
      @(negedge clk);
      bus.memread_i = 1'b1; bus.addr_i = 32'h40;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (bus.mem_req_o !== 1'b1) begin miscompares++; $display("FAIL mid_req_before: got %b want 1", bus.mem_req_o); end
      rst_n = 1'b0; bus.memread_i = 1'b0;
      #1;
      vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL mid_req_async: got %b want 0", bus.mem_req_o); end
      vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL mid_stall_async: got %b want 0", bus.stall_o); end
      vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL mid_err_cleared: got %b want 0", bus.err_o); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0BAD0;
      @(negedge clk);
      bus.mem_ack_i = 1'b0; bus.mem_rdata_i = 32'd0;
      #1;
      vectors++; if (bus.rdata_o !== 32'd0) begin miscompares++; $display("FAIL stale_ack_rdata: got %h want 0", bus.rdata_o); end
      vectors++; if (bus.mem_req_o !== 1'b0) begin miscompares++; $display("FAIL stale_ack_req: got %b want 0", bus.mem_req_o); end
      push_exp(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1);
      do_access(1'b1, 1'b0, 32'h30, 32'h0, 1, 32'hCAFEF00D, o, f, d);
      check_txn("post_rst", o);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_perf();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
